// File: rtl/riscv_pkg.sv
// RV32I/RV64I opcode and funct7 constants plus the decoded-entry control record
// shared by the decoder and the decode queue.
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FUNCT3_W   = 3;
    localparam int unsigned FUNCT7_W   = 7;

    // Everything in a decoded entry except the XLEN-wide immediate and PC.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [FUNCT3_W-1:0]   funct3;
        logic [FUNCT7_W-1:0]   funct7;
        logic                  alu_sel;
        logic                  rd_we;
        logic                  illegal;
    } dec_ctrl_t;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I/RV64I instruction decoder: register addresses,
// funct fields, control flags, illegal detection and XLEN sign-extended immediate.
module decode_comb
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output dec_ctrl_t       ctrl_o,
    output logic [XLEN-1:0] imm_o
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [31:0] imm32;
    logic        ill;
    dec_ctrl_t   ctrl;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign imm_u  = {instr_i[31:12], 12'b0};

    always_comb begin
        ctrl  = '0;
        imm32 = '0;
        ill   = (instr_i[1:0] != 2'b11);
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                ctrl.rd = instr_i[11:7]; ctrl.alu_sel = 1'b1; ctrl.rd_we = 1'b1; imm32 = imm_u;
            end
            OP_JAL: begin
                ctrl.rd = instr_i[11:7]; ctrl.alu_sel = 1'b1; ctrl.rd_we = 1'b1; imm32 = imm_j;
            end
            OP_JALR, OP_LOAD: begin
                ctrl.rd = instr_i[11:7]; ctrl.rs1 = instr_i[19:15]; ctrl.funct3 = f3;
                ctrl.alu_sel = 1'b1; ctrl.rd_we = 1'b1; imm32 = imm_i;
                if (opcode == OP_JALR && f3 != 3'b000) ill = 1'b1;
            end
            OP_STORE: begin
                ctrl.rs1 = instr_i[19:15]; ctrl.rs2 = instr_i[24:20]; ctrl.alu_sel = 1'b1; imm32 = imm_s;
            end
            OP_OP_IMM: begin
                ctrl.rd = instr_i[11:7]; ctrl.rs1 = instr_i[19:15]; ctrl.funct3 = f3;
                ctrl.alu_sel = 1'b1; ctrl.rd_we = 1'b1; imm32 = imm_i;
                // Shifts carry their funct7 so the ALU can tell SRLI from SRAI.
                if (f3 == 3'b001 || f3 == 3'b101) ctrl.funct7 = f7;
                if (f3 == 3'b001 && f7 != F7_BASE) ill = 1'b1;
                if (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT) ill = 1'b1;
            end
            OP_OP: begin
                ctrl.rd = instr_i[11:7]; ctrl.rs1 = instr_i[19:15]; ctrl.rs2 = instr_i[24:20];
                ctrl.funct3 = f3; ctrl.funct7 = f7; ctrl.rd_we = 1'b1;
                if (f7 != F7_BASE && f7 != F7_ALT) ill = 1'b1;
                if (f7 == F7_ALT && f3 != 3'b000 && f3 != 3'b101) ill = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.rs1 = instr_i[19:15]; ctrl.rs2 = instr_i[24:20]; ctrl.funct3 = f3; imm32 = imm_b;
                if (f3[2:1] == 2'b01) ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        ctrl.rd_we = ctrl.rd_we & (ctrl.rd != '0);
        if (ill) begin
            ctrl         = '0;
            imm32        = '0;
            ctrl.illegal = 1'b1;
        end
    end

    assign ctrl_o = ctrl;
    assign imm_o  = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_queue.sv
// DEPTH-entry queue of decoded instructions between fetch and issue, with
// valid/ready on both sides, synchronous flush and PC carry-through.
module decode_queue
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_addr1,
    output logic [4:0]      out_addr2,
    output logic [4:0]      out_addr_dest,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_alu_sel,
    output logic            out_rd_we,
    output logic            out_illegal
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    dec_ctrl_t       dec_ctrl;
    logic [XLEN-1:0] dec_imm;

    decode_comb #(.XLEN(XLEN)) u_decode (
        .instr_i (in_instr),
        .ctrl_o  (dec_ctrl),
        .imm_o   (dec_imm)
    );

    dec_ctrl_t       ctrl_q [DEPTH];
    logic [XLEN-1:0] imm_q  [DEPTH];
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;

    assign in_ready  = (cnt_q != CNT_W'(DEPTH)) && !flush;
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // Power-of-two DEPTH lets the pointers wrap by natural overflow.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= '0;
                imm_q[i]  <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push) begin
                ctrl_q[wr_ptr_q] <= dec_ctrl;
                imm_q[wr_ptr_q]  <= dec_imm;
                pc_q[wr_ptr_q]   <= in_pc;
            end
        end
    end

    assign out_pc        = pc_q[rd_ptr_q];
    assign out_imm       = imm_q[rd_ptr_q];
    assign out_addr1     = ctrl_q[rd_ptr_q].rs1;
    assign out_addr2     = ctrl_q[rd_ptr_q].rs2;
    assign out_addr_dest = ctrl_q[rd_ptr_q].rd;
    assign out_funct3    = ctrl_q[rd_ptr_q].funct3;
    assign out_funct7    = ctrl_q[rd_ptr_q].funct7;
    assign out_alu_sel   = ctrl_q[rd_ptr_q].alu_sel;
    assign out_rd_we     = ctrl_q[rd_ptr_q].rd_we;
    assign out_illegal   = ctrl_q[rd_ptr_q].illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: a 32-bit/2-deep and a 64-bit/4-deep
// instance share the same stimulus; each has its own expected-entry queue.
module tb_decode_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_alu, a_we, a_ill;
    logic [31:0] a_out_pc, a_out_imm;
    logic [4:0]  a_addr1, a_addr2, a_dest;
    logic [2:0]  a_f3;
    logic [6:0]  a_f7;

    logic        b_in_ready, b_out_valid, b_alu, b_we, b_ill;
    logic [63:0] b_out_pc, b_out_imm;
    logic [4:0]  b_addr1, b_addr2, b_dest;
    logic [2:0]  b_f3;
    logic [6:0]  b_f7;

    decode_queue #(.XLEN(32), .DEPTH(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_out_pc), .out_addr1(a_addr1), .out_addr2(a_addr2), .out_addr_dest(a_dest),
        .out_funct3(a_f3), .out_funct7(a_f7), .out_imm(a_out_imm), .out_alu_sel(a_alu),
        .out_rd_we(a_we), .out_illegal(a_ill)
    );

    decode_queue #(.XLEN(64), .DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_out_pc), .out_addr1(b_addr1), .out_addr2(b_addr2), .out_addr_dest(b_dest),
        .out_funct3(b_f3), .out_funct7(b_f7), .out_imm(b_out_imm), .out_alu_sel(b_alu),
        .out_rd_we(b_we), .out_illegal(b_ill)
    );

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        alu, we, ill;
        logic [63:0] imm;
    } vec_t;

    typedef struct {
        int          idx;
        logic [63:0] pc;
    } sb_t;

    localparam int NVEC = 19;
    vec_t tbl [NVEC];
    sb_t  sb_a [$];
    sb_t  sb_b [$];
    int   cur_idx;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic init_table();
        tbl[0]  = '{32'hFFF10093, 5'd2, 5'd0, 5'd1,  3'd0, 7'h00, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF}; // addi x1,x2,-1
        tbl[1]  = '{32'h123452B7, 5'd0, 5'd0, 5'd5,  3'd0, 7'h00, 1'b1, 1'b1, 1'b0, 64'h0000_0000_1234_5000}; // lui x5
        tbl[2]  = '{32'h00322423, 5'd4, 5'd3, 5'd0,  3'd0, 7'h00, 1'b1, 1'b0, 1'b0, 64'h8};                   // sw x3,8(x4)
        tbl[3]  = '{32'h00000010, 5'd0, 5'd0, 5'd0,  3'd0, 7'h00, 1'b0, 1'b0, 1'b1, 64'h0};                   // bits[1:0]=00
        tbl[4]  = '{32'h40001033, 5'd0, 5'd0, 5'd0,  3'd0, 7'h00, 1'b0, 1'b0, 1'b1, 64'h0};                   // f7=20 f3=001
        tbl[5]  = '{32'h00208033, 5'd1, 5'd2, 5'd0,  3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 64'h0};                   // add x0,x1,x2
        tbl[6]  = '{32'h40208233, 5'd1, 5'd2, 5'd4,  3'd0, 7'h20, 1'b0, 1'b1, 1'b0, 64'h0};                   // sub x4,x1,x2
        tbl[7]  = '{32'hFE208EE3, 5'd1, 5'd2, 5'd0,  3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC}; // beq -4
        tbl[8]  = '{32'h008000EF, 5'd0, 5'd0, 5'd1,  3'd0, 7'h00, 1'b1, 1'b1, 1'b0, 64'h8};                   // jal x1,8
        tbl[9]  = '{32'h004280E7, 5'd5, 5'd0, 5'd1,  3'd0, 7'h00, 1'b1, 1'b1, 1'b0, 64'h4};                   // jalr x1,4(x5)
        tbl[10] = '{32'h004290E7, 5'd0, 5'd0, 5'd0,  3'd0, 7'h00, 1'b0, 1'b0, 1'b1, 64'h0};                   // jalr f3=001
        tbl[11] = '{32'hFF83A303, 5'd7, 5'd0, 5'd6,  3'd2, 7'h00, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8}; // lw x6,-8(x7)
        tbl[12] = '{32'h00519193, 5'd3, 5'd0, 5'd3,  3'd1, 7'h00, 1'b1, 1'b1, 1'b0, 64'h5};                   // slli x3,x3,5
        tbl[13] = '{32'h4051D193, 5'd3, 5'd0, 5'd3,  3'd5, 7'h20, 1'b1, 1'b1, 1'b0, 64'h405};                 // srai x3,x3,5
        tbl[14] = '{32'h80000517, 5'd0, 5'd0, 5'd10, 3'd0, 7'h00, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000}; // auipc x10
        tbl[15] = '{32'h00002063, 5'd0, 5'd0, 5'd0,  3'd0, 7'h00, 1'b0, 1'b0, 1'b1, 64'h0};                   // branch f3=010
        tbl[16] = '{32'h0000007F, 5'd0, 5'd0, 5'd0,  3'd0, 7'h00, 1'b0, 1'b0, 1'b1, 64'h0};                   // bad opcode
        tbl[17] = '{32'h02208033, 5'd0, 5'd0, 5'd0,  3'd0, 7'h00, 1'b0, 1'b0, 1'b1, 64'h0};                   // OP f7=01
        tbl[18] = '{32'h40519193, 5'd0, 5'd0, 5'd0,  3'd0, 7'h00, 1'b0, 1'b0, 1'b1, 64'h0};                   // slli f7=20
    endtask

    task automatic drive(input int idx, input logic [63:0] pc);
        cur_idx  = idx;
        in_valid = 1'b1;
        in_instr = tbl[idx].instr;
        in_pc    = pc;
    endtask

    // Called at a falling edge: records pops/pushes for both instances, then advances one cycle.
    task automatic tick();
        sb_t         e;
        logic [27:0] act_f, exp_f;
        #1;
        if (flush) begin
            n_checks++;
            if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_in_ready: got a=%b b=%b, want 0", a_in_ready, b_in_ready);
            end
        end else begin
            if (a_out_valid && out_ready) begin
                n_checks++;
                if (sb_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL a_extra_entry: got out_valid=1 pc=%h, want no entry", a_out_pc);
                end else begin
                    e     = sb_a.pop_front();
                    exp_f = {tbl[e.idx].rs1, tbl[e.idx].rs2, tbl[e.idx].rd, tbl[e.idx].f3, tbl[e.idx].f7,
                             tbl[e.idx].alu, tbl[e.idx].we, tbl[e.idx].ill};
                    act_f = {a_addr1, a_addr2, a_dest, a_f3, a_f7, a_alu, a_we, a_ill};
                    if (act_f !== exp_f) begin
                        n_fail++;
                        $display("FAIL a_fields[%0d]: got %h, want %h", e.idx, act_f, exp_f);
                    end
                    n_checks++;
                    if (a_out_imm !== tbl[e.idx].imm[31:0]) begin
                        n_fail++;
                        $display("FAIL a_imm[%0d]: got %h, want %h", e.idx, a_out_imm, tbl[e.idx].imm[31:0]);
                    end
                    n_checks++;
                    if (a_out_pc !== e.pc[31:0]) begin
                        n_fail++;
                        $display("FAIL a_pc[%0d]: got %h, want %h", e.idx, a_out_pc, e.pc[31:0]);
                    end
                end
            end
            if (b_out_valid && out_ready) begin
                n_checks++;
                if (sb_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL b_extra_entry: got out_valid=1 pc=%h, want no entry", b_out_pc);
                end else begin
                    e     = sb_b.pop_front();
                    exp_f = {tbl[e.idx].rs1, tbl[e.idx].rs2, tbl[e.idx].rd, tbl[e.idx].f3, tbl[e.idx].f7,
                             tbl[e.idx].alu, tbl[e.idx].we, tbl[e.idx].ill};
                    act_f = {b_addr1, b_addr2, b_dest, b_f3, b_f7, b_alu, b_we, b_ill};
                    if (act_f !== exp_f) begin
                        n_fail++;
                        $display("FAIL b_fields[%0d]: got %h, want %h", e.idx, act_f, exp_f);
                    end
                    n_checks++;
                    if (b_out_imm !== tbl[e.idx].imm) begin
                        n_fail++;
                        $display("FAIL b_imm[%0d]: got %h, want %h", e.idx, b_out_imm, tbl[e.idx].imm);
                    end
                    n_checks++;
                    if (b_out_pc !== e.pc) begin
                        n_fail++;
                        $display("FAIL b_pc[%0d]: got %h, want %h", e.idx, b_out_pc, e.pc);
                    end
                end
            end
            if (in_valid && a_in_ready) begin
                e = '{cur_idx, in_pc};
                sb_a.push_back(e);
            end
            if (in_valid && b_in_ready) begin
                e = '{cur_idx, in_pc};
                sb_b.push_back(e);
            end
        end
        @(posedge clk);
        if (flush) begin
            sb_a.delete();
            sb_b.delete();
        end
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12 && (sb_a.size() != 0 || sb_b.size() != 0); i++) tick();
        #1;
        n_checks++;
        if (sb_a.size() != 0 || sb_b.size() != 0 || a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got pending a=%0d b=%0d out_valid a=%b b=%b, want all empty",
                     sb_a.size(), sb_b.size(), a_out_valid, b_out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got a=%b b=%b, want 0", a_out_valid, b_out_valid);
        end
        n_checks++;
        if ({a_out_pc, a_out_imm, a_addr1, a_addr2, a_dest, a_f3, a_f7, a_alu, a_we, a_ill} !== '0 ||
            {b_out_pc, b_out_imm, b_addr1, b_addr2, b_dest, b_f3, b_f7, b_alu, b_we, b_ill} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got a_pc=%h a_imm=%h b_pc=%h b_imm=%h, want all zero",
                     a_out_pc, a_out_imm, b_out_pc, b_out_imm);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got a=%b b=%b, want 1", a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_first_entry();
        out_ready = 1'b0;
        drive(0, 64'h100);
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_passthrough: got a=%b b=%b, want 0", a_out_valid, b_out_valid);
        end
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (a_out_valid !== 1'b1 || b_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_latency: got a=%b b=%b, want 1", a_out_valid, b_out_valid);
        end
        drain();
    endtask

    task automatic test_decode_stream();
        out_ready = 1'b1;
        for (int i = 1; i < NVEC; i++) begin
            drive(i, 64'hABCD_0000_0000_2000 + 64'(4 * i));
            tick();
        end
        drain();
    endtask

    task automatic test_full();
        for (int round = 0; round < 2; round++) begin
            out_ready = 1'b0;
            for (int i = 0; i < 6; i++) begin
                drive((i * 5 + round) % NVEC, 64'h3000 + 64'(16 * round + 4 * i));
                #1;
                n_checks++;
                if (a_in_ready !== (i < 2) || b_in_ready !== (i < 4)) begin
                    n_fail++;
                    $display("FAIL full_in_ready[%0d.%0d]: got a=%b b=%b, want a=%b b=%b",
                             round, i, a_in_ready, b_in_ready, i < 2, i < 4);
                end
                tick();
            end
            drain();
            // Shift the pointers so the second round fills across the wrap point.
            drive(13, 64'h3800);
            tick();
            drain();
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(6, 64'h4000);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive((i * 3 + 1) % NVEC, 64'h4004 + 64'(4 * i));
            #1;
            n_checks++;
            if (a_out_valid !== 1'b1 || b_out_valid !== 1'b1 || a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got valid a=%b b=%b ready a=%b b=%b, want all 1",
                         i, a_out_valid, b_out_valid, a_in_ready, b_in_ready);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1, 64'h5000); tick();
        drive(2, 64'h5004); tick();
        drive(8, 64'h5008);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_out_valid: got a=%b b=%b, want 0", a_out_valid, b_out_valid);
        end
        out_ready = 1'b0;
        drive(9, 64'h500C);
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_count: got a in_ready=%b out_valid=%b, want 1 1", a_in_ready, a_out_valid);
        end
        drain();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(11, 64'h6000); tick();
        drive(12, 64'h6004); tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || a_out_pc !== '0 || b_out_imm !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got valid a=%b b=%b a_pc=%h b_imm=%h, want 0",
                     a_out_valid, b_out_valid, a_out_pc, b_out_imm);
        end
        sb_a.delete();
        sb_b.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(14, 64'h6008);
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_count: got a in_ready=%b, want 1", a_in_ready);
        end
        drain();
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        cur_idx   = 0;
        init_table();
        @(negedge clk);
        test_reset();
        test_first_entry();
        test_decode_stream();
        test_full();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
